// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone definitions for wb_mem_pipe and its response pipeline.
//   - RD_LATENCY_MIN / RD_LATENCY_MAX : legal response latency range
//   - wb_rsp_t                        : response encoding (none / ack / err)
//   - wb_rsp_for()                    : picks the termination for an access
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        WB_RSP_NONE = 2'd0,
        WB_RSP_ACK  = 2'd1,
        WB_RSP_ERR  = 2'd2
    } wb_rsp_t;

    // Out-of-range accesses terminate with err only when error reporting is
    // enabled; otherwise every access is acknowledged normally.
    function automatic wb_rsp_t wb_rsp_for(input logic in_range, input logic err_en);
        if (!in_range && err_en) begin
            return WB_RSP_ERR;
        end
        return WB_RSP_ACK;
    endfunction

endpackage

// File: rtl/wb_mem_pipe_dly.sv
// ---------------------------------------------------------------------------
// wb_mem_pipe_dly
// Fixed-latency response pipeline for wb_mem_pipe. Every accepted request
// enters stage 0 and emerges RD_LATENCY cycles later as ack or err.
// Ports:
//   i_clk, i_rst   clock / synchronous active-high reset
//   i_cyc          Wishbone cycle; low flushes every in-flight response
//   i_valid        request accepted this cycle
//   i_rsp          response type for the request (wb_rsp_t encoding)
//   i_is_read      request is a read (its data drives o_data on response)
//   i_rdata        read data captured at acceptance
//   o_ack, o_err   terminations (never both, never while i_cyc low / i_rst)
//   o_data         read data; holds last read value otherwise, 0 in reset
// ---------------------------------------------------------------------------
module wb_mem_pipe_dly
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter bit ERR_EN     = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cyc,
    input  logic                  i_valid,
    input  logic [1:0]            i_rsp,
    input  logic                  i_is_read,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_ack,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int LAST = RD_LATENCY - 1;

    logic                  r_vld [RD_LATENCY];
    logic [1:0]            r_rsp [RD_LATENCY];
    logic                  r_rd  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] r_dat [RD_LATENCY];
    logic [DATA_WIDTH-1:0] r_hold;

    logic w_flush;
    logic w_live;
    logic w_live_rd;

    assign w_flush = i_rst || !i_cyc;

    // Only the valid bits need clearing; payload follows them blindly.
    always_ff @(posedge i_clk) begin
        if (w_flush) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_vld[k] <= 1'b0;
            end
        end else begin
            r_vld[0] <= i_valid;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_rsp[0] <= i_rsp;
        r_rd[0]  <= i_is_read;
        r_dat[0] <= i_rdata;
        for (int k = 1; k < RD_LATENCY; k++) begin
            r_rsp[k] <= r_rsp[k-1];
            r_rd[k]  <= r_rd[k-1];
            r_dat[k] <= r_dat[k-1];
        end
    end

    // The last stage is gated by the current i_cyc / i_rst so a response
    // due in a cycle where the master drops cyc is never presented.
    assign w_live    = r_vld[LAST] && !w_flush;
    assign w_live_rd = w_live && r_rd[LAST];

    assign o_ack  = w_live && (r_rsp[LAST] == WB_RSP_ACK);
    assign o_err  = ERR_EN && w_live && (r_rsp[LAST] == WB_RSP_ERR);
    assign o_data = i_rst ? '0 : (w_live_rd ? r_dat[LAST] : r_hold);

    // Remembers the last presented read data so o_data holds on
    // write responses and idle cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_live_rd) begin
            r_hold <= r_dat[LAST];
        end
    end

endmodule

// File: rtl/wb_mem_pipe.sv
// ---------------------------------------------------------------------------
// wb_mem_pipe
// Pipelined Wishbone memory slave: one request per cycle, never stalls,
// every request answered exactly RD_LATENCY cycles later, in order.
// Optional feature: define WB_MEM_PIPE_ERR_EN to terminate out-of-range
// accesses with o_wb_err instead of o_wb_ack.
// Ports:
//   i_clk, i_rst                 clock / synchronous active-high reset
//   i_wb_cyc, i_wb_stb, i_wb_we  cycle, strobe, write enable
//   i_wb_addr                    word address
//   i_wb_data, i_wb_sel          write data, byte enables
//   o_wb_stall                   always 0
//   o_wb_ack, o_wb_err           terminations
//   o_wb_data                    read data
// ---------------------------------------------------------------------------
module wb_mem_pipe
    import wb_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_NWORDS    = 1 << WB_ADDR_WIDTH,
    parameter int RD_LATENCY    = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    input  logic                      i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0]  i_wb_addr,
    input  logic [DATA_WIDTH-1:0]     i_wb_data,
    input  logic [DATA_WIDTH/8-1:0]   i_wb_sel,
    output logic                      o_wb_stall,
    output logic                      o_wb_ack,
    output logic                      o_wb_err,
    output logic [DATA_WIDTH-1:0]     o_wb_data
);

    localparam int          NBYTES   = DATA_WIDTH / 8;
    localparam int unsigned P_NWORDS = MEM_NWORDS;

`ifdef WB_MEM_PIPE_ERR_EN
    localparam bit P_ERR_EN = 1'b1;
`else
    localparam bit P_ERR_EN = 1'b0;
`endif

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("wb_mem_pipe: RD_LATENCY out of range");
    end

    // Zero at configuration; deliberately untouched by reset.
    logic [DATA_WIDTH-1:0] r_mem [0:MEM_NWORDS-1] = '{default: '0};

    logic                  w_accept;
    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_rdata;
    wb_rsp_t               w_rsp;

    assign w_accept   = i_wb_cyc && i_wb_stb && !i_rst;
    assign w_in_range = (32'(i_wb_addr) < P_NWORDS);

    // Reads sample the array before this edge's write; a write from the
    // previous cycle has already landed, so there is no stale data.
    assign w_rdata = w_in_range ? r_mem[i_wb_addr] : '0;
    assign w_rsp   = wb_rsp_for(w_in_range, P_ERR_EN);

    always_ff @(posedge i_clk) begin
        if (w_accept && i_wb_we && w_in_range) begin
            for (int n = 0; n < NBYTES; n++) begin
                if (i_wb_sel[n]) begin
                    r_mem[i_wb_addr][8*n +: 8] <= i_wb_data[8*n +: 8];
                end
            end
        end
    end

    assign o_wb_stall = 1'b0;

    wb_mem_pipe_dly #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY),
        .ERR_EN     (P_ERR_EN)
    ) u_dly (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_cyc     (i_wb_cyc),
        .i_valid   (w_accept),
        .i_rsp     (w_rsp),
        .i_is_read (!i_wb_we),
        .i_rdata   (w_rdata),
        .o_ack     (o_wb_ack),
        .o_err     (o_wb_err),
        .o_data    (o_wb_data)
    );

endmodule

// File: tb/tb_wb_mem_pipe.sv
// ---------------------------------------------------------------------------
// tb_wb_mem_pipe
// Three wb_mem_pipe instances share one stimulus stream:
//   0: RD_LATENCY=3, MEM_NWORDS=48   1: RD_LATENCY=2, 64 words
//   2: RD_LATENCY=4, 64 words
// A queue-of-due-responses model predicts ack/err/data for every cycle.
// ---------------------------------------------------------------------------
module tb_wb_mem_pipe;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int NI = 3;

`ifdef WB_MEM_PIPE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset / stimulus signals ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;

    logic          stall_v [NI];
    logic          ack_v   [NI];
    logic          err_v   [NI];
    logic [DW-1:0] data_v  [NI];

    always #5 clk = ~clk;

    wb_mem_pipe #(.WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_NWORDS(48), .RD_LATENCY(3)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall_v[0]), .o_wb_ack(ack_v[0]), .o_wb_err(err_v[0]), .o_wb_data(data_v[0])
    );

    wb_mem_pipe #(.WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_NWORDS(64), .RD_LATENCY(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall_v[1]), .o_wb_ack(ack_v[1]), .o_wb_err(err_v[1]), .o_wb_data(data_v[1])
    );

    wb_mem_pipe #(.WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_NWORDS(64), .RD_LATENCY(4)) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall_v[2]), .o_wb_ack(ack_v[2]), .o_wb_err(err_v[2]), .o_wb_data(data_v[2])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic int nw_of(input int k);
        return (k == 0) ? 48 : 64;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            is_err;
        bit            is_rd;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          pend_q [NI][$];
    logic [DW-1:0] mem_m  [NI][64];
    logic [DW-1:0] hold_m [NI];
    int            cyc_n;

    // A response is presented when it is due now and the bus is live.
    function automatic bit head_live(input int k);
        if (rst || !cyc || pend_q[k].size() == 0) return 1'b0;
        return pend_q[k][0].due == cyc_n;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            bit   live;
            bit   inr;
            rsp_t r;
            live = head_live(k);
            if (rst) hold_m[k] = '0;
            else if (live && pend_q[k][0].is_rd) hold_m[k] = pend_q[k][0].data;
            if (live) void'(pend_q[k].pop_front());
            if (rst || !cyc) begin
                pend_q[k].delete();
            end else if (stb) begin
                inr      = (int'(addr) < nw_of(k));
                r.due    = cyc_n + lat_of(k);
                r.is_err = !inr && ERR_EN;
                r.is_rd  = !we;
                r.data   = inr ? mem_m[k][addr] : '0;
                if (we && inr) begin
                    for (int b = 0; b < SW; b++) begin
                        if (sel[b]) mem_m[k][addr][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
                pend_q[k].push_back(r);
            end
        end
        cyc_n = cyc_n + 1;
    end

    // ---------------- scoreboard ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    bit            chk_en  = 1'b0;
    int            ev_q     [NI][$];
    int            err_n    [NI];
    logic [DW-1:0] last_data[NI];

    task automatic chk(input string name, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc_n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                bit            live;
                logic [DW-1:0] exp_d;
                live  = head_live(k);
                exp_d = rst ? '0 : ((live && pend_q[k][0].is_rd) ? pend_q[k][0].data : hold_m[k]);
                chk("stall", k, 32'(stall_v[k]), 32'(1'b0));
                chk("ack",   k, 32'(ack_v[k]),   32'(live && !pend_q[k][0].is_err));
                chk("err",   k, 32'(err_v[k]),   32'(live && pend_q[k][0].is_err));
                chk("data",  k, data_v[k],       exp_d);
                if (ack_v[k] === 1'b1 || err_v[k] === 1'b1) begin
                    ev_q[k].push_back(cyc_n);
                    last_data[k] = data_v[k];
                end
                if (err_v[k] === 1'b1) err_n[k]++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] sl);
        @(posedge clk);
        #1;
        rst = r; cyc = c; stb = s; we = w; addr = a; wdata = d; sel = sl;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] sl);
        drive(1'b0, 1'b1, 1'b1, 1'b1, a, d, sl);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b0, 1'b1, 1'b1, 1'b0, a, $urandom, SW'($urandom_range(0, 15)));
    endtask

    // Idle with cyc held high; the ignored fields carry garbage.
    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)),
                         AW'($urandom_range(0, 63)), $urandom, SW'($urandom_range(0, 15)));
    endtask

    task automatic clear_ev();
        for (int k = 0; k < NI; k++) ev_q[k].delete();
    endtask

    // ---------------- main sequence ----------------
    int c0;
    int e0;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = '0; cyc_n = 0;
        for (int k = 0; k < NI; k++) begin
            hold_m[k] = '0; err_n[k] = 0; last_data[k] = '0;
            for (int i = 0; i < 64; i++) mem_m[k][i] = '0;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd9, 32'hFFFF_FFFF, 4'hF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);

        // write then read-after-write, latency 3 on instance 0
        clear_ev();
        wr(6'd5, 32'hDEAD_BEEF, 4'hF);
        c0 = cyc_n;
        rd(6'd5);
        idle(6);
        chk("raw_resp_count", 0, ev_q[0].size(), 2);
        chk("raw_wr_ack_cycle", 0, ev_q[0].size() > 0 ? ev_q[0][0] : -1, c0 + 3);
        chk("raw_rd_ack_cycle", 0, ev_q[0].size() > 1 ? ev_q[0][1] : -1, c0 + 4);
        chk("raw_rd_data", 0, last_data[0], 32'hDEAD_BEEF);

        // 8 back-to-back reads, latency 2 on instance 1
        for (int i = 0; i < 8; i++) wr(AW'(i), 32'h1000_0000 + i, 4'hF);
        idle(5);
        clear_ev();
        for (int i = 0; i < 8; i++) begin
            rd(AW'(i));
            if (i == 0) c0 = cyc_n;
        end
        idle(5);
        chk("burst_count", 1, ev_q[1].size(), 8);
        chk("burst_first", 1, ev_q[1].size() > 0 ? ev_q[1][0] : -1, c0 + 2);
        chk("burst_last", 1, ev_q[1].size() > 7 ? ev_q[1][7] : -1, c0 + 9);
        chk("burst_last_data", 1, last_data[1], 32'h1000_0007);

        // byte-enable merge
        wr(6'd2, 32'h1122_3344, 4'hF);
        wr(6'd2, 32'hAABB_CCDD, 4'h5);
        rd(6'd2);
        idle(6);
        for (int k = 0; k < NI; k++) chk("sel_merge", k, last_data[k], 32'h11BB_33DD);

        // out-of-range on instance 0 (48 words)
        clear_ev();
        e0 = err_n[0];
        wr(6'd50, 32'h5A5A_5A5A, 4'hF);
        rd(6'd50);
        idle(6);
        chk("oor_resp_count", 0, ev_q[0].size(), 2);
        chk("oor_err_count", 0, err_n[0] - e0, ERR_EN ? 2 : 0);
        chk("oor_rd_data", 0, last_data[0], 32'h0);
        chk("inr_rd_data", 1, last_data[1], 32'h5A5A_5A5A);
        for (int i = 0; i < 48; i++) rd(AW'(i));
        idle(6);

        // cyc drop with reads in flight, latency 4 on instance 2
        clear_ev();
        rd(6'd1); rd(6'd2); rd(6'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd7, 32'hFFFF_FFFF, 4'hF);
        idle(6);
        chk("drop_no_resp", 2, ev_q[2].size(), 0);
        clear_ev();
        rd(6'd7);
        c0 = cyc_n;
        idle(6);
        chk("after_drop_count", 2, ev_q[2].size(), 1);
        chk("after_drop_cycle", 2, ev_q[2].size() > 0 ? ev_q[2][0] : -1, c0 + 4);
        chk("after_drop_data", 2, last_data[2], 32'h1000_0007);

        // reset pulse with two requests in flight
        clear_ev();
        rd(6'd2); rd(6'd3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd2, 32'h0, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        idle(6);
        for (int k = 0; k < NI; k++) chk("rst_no_resp", k, ev_q[k].size(), 0);
        rd(6'd2);
        idle(6);
        for (int k = 0; k < NI; k++) chk("rst_mem_kept", k, last_data[k], 32'h11BB_33DD);

        // randomized traffic
        repeat (3000) begin
            drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 15) != 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 63)), $urandom, SW'($urandom_range(0, 15)));
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
